// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants, state encoding and word helpers for the two-way
// write-through data cache (cache_controller + cache_set_array).
//   INDEX_W             : set-index width for the default 64-set cache
//   TAG_W               : stored tag width
//   DEFAULT_ADDR_OFFSET : data-memory base removed before field extraction
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int          INDEX_W             = 6;
  localparam int          TAG_W               = 11;
  localparam logic [31:0] DEFAULT_ADDR_OFFSET = 32'd1024;

  // Legacy-compatible raw encodings; the enum below is built on them so
  // waveforms and older tooling see the same values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    WRITE = ST_WRITE
  } cache_state_e;

  // The lower-addressed word of a line lives in [63:32].
  function automatic logic [31:0] select_word(input logic [63:0] line,
                                              input logic        word_sel);
    return word_sel ? line[31:0] : line[63:32];
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] line,
                                             input logic        word_sel,
                                             input logic [31:0] data);
    return word_sel ? {line[63:32], data} : {data, line[31:0]};
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// -----------------------------------------------------------------------------
// cache_controller_if
// Bundles the memory-stage request/response signals and the SRAM-controller
// side signals of the data cache.
//   slave  : the cache (consumes pipeline requests, drives SRAM requests)
//   master : the environment (pipeline + SRAM controller)
// -----------------------------------------------------------------------------
interface cache_controller_if;

  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;

  modport slave (
    input  read_en, write_en, address, write_data, sram_read_data, sram_ready,
    output read_data, ready, sram_read_en, sram_write_en, sram_address,
           sram_write_data
  );

  modport master (
    output read_en, write_en, address, write_data, sram_read_data, sram_ready,
    input  read_data, ready, sram_read_en, sram_write_en, sram_address,
           sram_write_data
  );

endinterface

// File: rtl/cache_set_array.sv
// -----------------------------------------------------------------------------
// cache_set_array
// Storage for the two-way cache: per-way valid, tag and 64-bit line, plus one
// LRU bit per set naming the next victim way.
//   clk      : rising-edge clock
//   clear    : synchronous clear of all valid and LRU bits (tags/data kept)
//   rd_*     : combinational read of every way of set rd_index
//   wr_en    : write strobe; always updates the LRU bit of wr_index
//   wr_line  : with wr_en, also writes valid/tag/data of way wr_way
// -----------------------------------------------------------------------------
module cache_set_array
  import cache_pkg::*;
#(
  parameter int SETS  = 1 << INDEX_W,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic [IDX_W-1:0]          rd_index,
  output logic [1:0]                rd_valid,
  output logic [1:0][TAG_W-1:0]     rd_tag,
  output logic [1:0][63:0]          rd_data,
  output logic                      rd_lru,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_index,
  input  logic                      wr_line,
  input  logic                      wr_way,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [63:0]               wr_data,
  input  logic                      wr_lru
);

  logic [SETS-1:0][1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [63:0]          data_q [2][SETS];

  // Control bits are the only state that must be cleared; a line is never
  // trusted unless its valid bit is set.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else if (wr_en) begin
      lru_q[wr_index] <= wr_lru;
      if (wr_line) begin
        valid_q[wr_index][wr_way] <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!clear && wr_en && wr_line) begin
      tag_q[wr_way][wr_index]  <= wr_tag;
      data_q[wr_way][wr_index] <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_lru   = lru_q[rd_index];
    for (int w = 0; w < 2; w++) begin
      rd_tag[w]  = tag_q[w][rd_index];
      rd_data[w] = data_q[w][rd_index];
    end
  end

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// Two-way set-associative, write-through, no-write-allocate data cache with
// one 64-bit line per way. Read hits complete in the request cycle; misses
// fill from the SRAM controller; every store is forwarded to SRAM and
// updates the cached copy only on a hit.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset (clears valid/LRU, aborts transfers)
//   bus : cache_controller_if.slave -- pipeline request/response and SRAM
//         controller request/response signals
// SETS must be a power of two.
// -----------------------------------------------------------------------------
module cache_controller
  import cache_pkg::*;
#(
  parameter int          SETS        = 1 << INDEX_W,
  parameter logic [31:0] ADDR_OFFSET = DEFAULT_ADDR_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);

  localparam int IDX_W = $clog2(SETS);

  cache_state_e state_q;
  cache_state_e state_d;

  logic [31:0]          offset_addr;
  logic                 word_sel;
  logic [IDX_W-1:0]     index;
  logic [TAG_W-1:0]     tag;
  logic                 unused_addr_bits;

  logic [1:0]            rd_valid;
  logic [1:0][TAG_W-1:0] rd_tag;
  logic [1:0][63:0]      rd_data;
  logic                  rd_lru;

  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  logic [63:0] hit_line;
  logic        victim;

  logic        ready;
  logic [31:0] read_data;
  logic        sram_read_en;
  logic        sram_write_en;
  logic        wr_en;
  logic        wr_line;
  logic        wr_way;
  logic [63:0] wr_data;
  logic        wr_lru;

  assign offset_addr      = bus.address - ADDR_OFFSET;
  assign word_sel         = offset_addr[2];
  assign index            = offset_addr[3 +: IDX_W];
  assign tag              = offset_addr[3 + IDX_W +: TAG_W];
  assign unused_addr_bits = ^{offset_addr[31:3 + IDX_W + TAG_W], offset_addr[1:0]};

  // Fills always land in the victim way, so both ways can never hold the
  // same tag and at most one compare can fire.
  assign hit0     = rd_valid[0] && (rd_tag[0] == tag);
  assign hit1     = rd_valid[1] && (rd_tag[1] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_line = rd_data[hit_way];

  // Empty ways are filled before anything is evicted.
  assign victim = !rd_valid[0] ? 1'b0 :
                  !rd_valid[1] ? 1'b1 : rd_lru;

  // Next-state and output decode. Stores win over loads, and a request that
  // is dropped mid-transfer returns to IDLE without touching the arrays.
  always_comb begin
    state_d       = state_q;
    ready         = 1'b1;
    read_data     = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    wr_en         = 1'b0;
    wr_line       = 1'b0;
    wr_way        = hit_way;
    wr_data       = merge_word(hit_line, word_sel, bus.write_data);
    wr_lru        = ~hit_way;

    case (state_q)
      IDLE: begin
        if (bus.write_en) begin
          ready   = 1'b0;
          state_d = WRITE;
        end else if (bus.read_en) begin
          if (hit) begin
            read_data = select_word(hit_line, word_sel);
            wr_en     = 1'b1;
          end else begin
            ready   = 1'b0;
            state_d = FILL;
          end
        end
      end

      FILL: begin
        sram_read_en = 1'b1;
        ready        = bus.sram_ready;
        if (!bus.read_en) begin
          state_d = IDLE;
        end else if (bus.sram_ready) begin
          read_data = select_word(bus.sram_read_data, word_sel);
          wr_en     = 1'b1;
          wr_line   = 1'b1;
          wr_way    = victim;
          wr_data   = bus.sram_read_data;
          wr_lru    = ~victim;
          state_d   = IDLE;
        end
      end

      WRITE: begin
        sram_write_en = 1'b1;
        ready         = bus.sram_ready;
        if (!bus.write_en) begin
          state_d = IDLE;
        end else if (bus.sram_ready) begin
          wr_en   = hit;
          wr_line = hit;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Leaving FILL/WRITE right after sram_ready drops the enables for a cycle,
  // letting the SRAM controller restart its sequence for the next request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  cache_set_array #(
    .SETS (SETS)
  ) u_set_array (
    .clk      (clk),
    .clear    (!rst),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_lru   (rd_lru),
    .wr_en    (wr_en && rst),
    .wr_index (index),
    .wr_line  (wr_line),
    .wr_way   (wr_way),
    .wr_tag   (tag),
    .wr_data  (wr_data),
    .wr_lru   (wr_lru)
  );

  assign bus.ready           = ready;
  assign bus.read_data       = read_data;
  assign bus.sram_read_en    = sram_read_en;
  assign bus.sram_write_en   = sram_write_en;
  assign bus.sram_address    = bus.address;
  assign bus.sram_write_data = bus.write_data;

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
// Self-checking bench for cache_controller. The bench plays both the pipeline
// and the SRAM controller. Its reference keeps a word-addressed backing
// memory (write-through means the cache can never disagree with it) and, per
// set, the two resident line numbers ordered by recency.
// -----------------------------------------------------------------------------
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_controller_if bus ();

  cache_controller #(
    .SETS        (64),
    .ADDR_OFFSET (32'd1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  int          m_mru [64];
  int          m_old [64];

  // Reference model ---------------------------------------------------------

  function automatic int line_of(input logic [31:0] a);
    return int'((a - 32'd1024) >> 3);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5C3_0F96;
  endfunction

  function automatic bit resident(input logic [31:0] a);
    int ln;
    ln = line_of(a);
    return (m_mru[ln % 64] == ln) || (m_old[ln % 64] == ln);
  endfunction

  function automatic void touch(input logic [31:0] a);
    int ln;
    int s;
    ln = line_of(a);
    s  = ln % 64;
    if (m_mru[s] != ln) begin
      m_old[s] = m_mru[s];
      m_mru[s] = ln;
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      m_mru[s] = -1;
      m_old[s] = -1;
    end
  endfunction

  // Checking and stimulus tasks --------------------------------------------

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.read_en        = 1'b0;
    bus.write_en       = 1'b0;
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_output("reset_ready", bus.ready, 1);
    check_output("reset_sram_rd", bus.sram_read_en, 0);
    check_output("reset_sram_wr", bus.sram_write_en, 0);
  endtask

  // One complete pipeline request, with the bench answering as the SRAM
  // controller after lat cycles of the transfer state.
  task automatic apply_stimulus(input bit rd, input bit wr,
                                input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat);
    bit          exp_hit;
    logic [31:0] exp_word;
    logic [31:0] base;
    logic [63:0] line;
    @(posedge clk); #1;
    bus.read_en    = rd;
    bus.write_en   = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    bus.sram_ready = 1'b0;
    exp_hit  = rd && !wr && resident(addr);
    exp_word = mem_rd(addr);
    @(negedge clk);
    check_output("idle_ready", bus.ready, exp_hit);
    check_output("idle_sram_rd", bus.sram_read_en, 0);
    check_output("idle_sram_wr", bus.sram_write_en, 0);
    if (exp_hit) begin
      check_output("hit_data", bus.read_data, exp_word);
      @(posedge clk); #1;
      clear_inputs();
      touch(addr);
    end else begin
      base = {addr[31:3], 3'b000};
      line = {mem_rd(base), mem_rd(base + 32'd4)};
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        bus.sram_ready     = (k == lat);
        bus.sram_read_data = (!wr && k == lat) ? line : {$urandom(), $urandom()};
        @(negedge clk);
        check_output("xfer_sram_rd", bus.sram_read_en, !wr);
        check_output("xfer_sram_wr", bus.sram_write_en, wr);
        check_output("xfer_ready", bus.ready, k == lat);
        check_output("xfer_sram_addr", bus.sram_address, addr);
        if (wr) check_output("xfer_sram_wdata", bus.sram_write_data, wdata);
        if (!wr && k == lat) check_output("fill_data", bus.read_data, exp_word);
      end
      @(posedge clk); #1;
      clear_inputs();
      if (wr) begin
        if (resident(addr)) touch(addr);
        mem[addr] = wdata;
      end else begin
        touch(addr);
      end
    end
    @(negedge clk);
    check_output("post_sram_rd", bus.sram_read_en, 0);
    check_output("post_sram_wr", bus.sram_write_en, 0);
    check_output("post_ready", bus.ready, 1);
  endtask

  // Watchdog: every wait above is a bounded cycle count, this only guards
  // against a simulator-level stall.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed steps followed by a randomized run ------------------------------
  initial begin
    logic [31:0] addr;
    int          kind;

    rst            = 1'b0;
    bus.address    = 32'd1024;
    bus.write_data = '0;
    clear_inputs();
    model_reset();
    mem[32'd1024] = 32'h1111_1111;
    mem[32'd1028] = 32'h2222_2222;

    $display("[TB] reset and cold read");
    do_reset();
    apply_stimulus(1, 0, 32'd1024, 32'h0, 3);
    apply_stimulus(1, 0, 32'd1028, 32'h0, 1);

    $display("[TB] write hit then read back");
    apply_stimulus(0, 1, 32'd1028, 32'hDEAD_BEEF, 2);
    apply_stimulus(1, 0, 32'd1028, 32'h0, 1);

    $display("[TB] eviction in set 0");
    apply_stimulus(1, 0, 32'd1536, 32'h0, 2);
    apply_stimulus(1, 0, 32'd2048, 32'h0, 1);
    apply_stimulus(1, 0, 32'd1536, 32'h0, 1);
    apply_stimulus(1, 0, 32'd1024, 32'h0, 2);

    $display("[TB] no write allocate");
    do_reset();
    apply_stimulus(0, 1, 32'd4096, 32'hCAFE_F00D, 3);
    apply_stimulus(1, 0, 32'd4096, 32'h0, 2);

    $display("[TB] read and write together");
    do_reset();
    apply_stimulus(1, 1, 32'd1024, 32'h1234_5678, 2);
    apply_stimulus(1, 0, 32'd1024, 32'h0, 1);

    $display("[TB] reset during fill");
    do_reset();
    apply_stimulus(1, 0, 32'd1536, 32'h0, 1);
    @(posedge clk); #1;
    bus.read_en = 1'b1;
    bus.address = 32'd1024;
    @(negedge clk);
    check_output("rstfill_idle_ready", bus.ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rstfill_sram_rd", bus.sram_read_en, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.read_en = 1'b0;
    model_reset();
    @(negedge clk);
    check_output("rstfill_after_rd", bus.sram_read_en, 0);
    check_output("rstfill_after_wr", bus.sram_write_en, 0);
    check_output("rstfill_after_ready", bus.ready, 1);
    apply_stimulus(1, 0, 32'd1024, 32'h0, 2);
    apply_stimulus(1, 0, 32'd1536, 32'h0, 1);

    $display("[TB] request dropped during fill");
    @(posedge clk); #1;
    bus.read_en = 1'b1;
    bus.address = 32'd2560;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("abort_sram_rd", bus.sram_read_en, 1);
    check_output("abort_ready", bus.ready, 0);
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("abort_idle_rd", bus.sram_read_en, 0);
    check_output("abort_idle_ready", bus.ready, 1);
    apply_stimulus(1, 0, 32'd2560, 32'h0, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      addr = 32'd1024 + 32'($urandom_range(0, 3)) * 32'd512
                      + 32'($urandom_range(0, 3)) * 32'd8
                      + 32'($urandom_range(0, 1)) * 32'd4;
      kind = int'($urandom_range(0, 4));
      apply_stimulus(kind != 0, kind <= 1, addr, $urandom(),
                     int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
